// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time instruction memory writer.
// Packs a big-endian byte stream into 32-bit words, writes them at byte
// addresses 0, 4, 8, ... and holds the fetch unit in reset until the
// requested number of words has been written.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   WordCount,
  input  logic [7:0]            InByte,
  input  logic                  InValid,
  output logic                  InReady,
  output logic                  MemWrite,
  output logic [31:0]           MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  CpuReset,
  output logic                  Busy,
  output logic                  Done,
  output logic [31:0]           Checksum
);

  // Count and word index need one extra bit to represent a full-capacity load.
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [CW-1:0] word_idx, word_idx_n;
  logic [CW-1:0] count, count_n;
  logic [23:0]   shift, shift_n;
  logic [31:0]   addr_n, wdata_n, csum_n;

  logic [CW-1:0] count_clamp_c;
  logic [CW-1:0] word_idx_inc_c;
  logic          xfer_c;

  // Any request with the top bit set is at or beyond capacity.
  assign count_clamp_c  = WordCount[ADDR_WIDTH] ? CAP : WordCount;
  assign word_idx_inc_c = word_idx + CW'(1);
  assign xfer_c         = InValid & InReady;

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-value logic for the datapath and outputs.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    word_idx_n = word_idx;
    count_n    = count;
    shift_n    = shift;
    addr_n     = MemAddress;
    wdata_n    = MemWriteData;
    csum_n     = Checksum;

    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          count_n    = count_clamp_c;
          csum_n     = 32'd0;
          byte_idx_n = 2'd0;
          word_idx_n = '0;
          state_n    = (count_clamp_c == '0) ? DONE : RECV;
        end
      end

      RECV: begin
        if (xfer_c) begin
          shift_n    = {shift[15:0], InByte};
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Fourth byte completes the word; present it on the write port.
            state_n = WRITE;
            addr_n  = 32'({word_idx[ADDR_WIDTH-1:0], 2'b00});
            wdata_n = {shift, InByte};
          end
        end
      end

      WRITE: begin
        csum_n     = Checksum ^ MemWriteData;
        word_idx_n = word_idx_inc_c;
        byte_idx_n = 2'd0;
        state_n    = (word_idx_inc_c == count) ? DONE : RECV;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      byte_idx     <= 2'd0;
      word_idx     <= '0;
      count        <= '0;
      shift        <= 24'd0;
      MemAddress   <= 32'd0;
      MemWriteData <= 32'd0;
      Checksum     <= 32'd0;
      InReady      <= 1'b0;
      MemWrite     <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      CpuReset     <= 1'b1;
    end else begin
      byte_idx     <= byte_idx_n;
      word_idx     <= word_idx_n;
      count        <= count_n;
      shift        <= shift_n;
      MemAddress   <= addr_n;
      MemWriteData <= wdata_n;
      Checksum     <= csum_n;
      InReady      <= (state_n == RECV);
      MemWrite     <= (state_n == WRITE);
      Busy         <= (state_n == RECV) || (state_n == WRITE);
      Done         <= (state_n == DONE);
      CpuReset     <= (state_n != DONE);
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader (default width plus a 2-bit capacity instance).
module tb_instr_mem_loader;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [8:0]  WordCount;
  logic [7:0]  InByte;
  logic        InValid;

  logic        InReady, MemWrite, CpuReset, Busy, Done;
  logic [31:0] MemAddress, MemWriteData, Checksum;

  logic        InReady2, MemWrite2, CpuReset2, Busy2, Done2;
  logic [31:0] MemAddress2, MemWriteData2, Checksum2;
  logic [2:0]  WordCount2;

  assign WordCount2 = WordCount[2:0];

  instr_mem_loader #(.ADDR_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount),
    .InByte(InByte), .InValid(InValid), .InReady(InReady),
    .MemWrite(MemWrite), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .CpuReset(CpuReset), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount2),
    .InByte(InByte), .InValid(InValid), .InReady(InReady2),
    .MemWrite(MemWrite2), .MemAddress(MemAddress2), .MemWriteData(MemWriteData2),
    .CpuReset(CpuReset2), .Busy(Busy2), .Done(Done2), .Checksum(Checksum2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Write monitors for both instances.
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  int          wr_n = 0;
  logic [31:0] wr2_addr [0:63];
  logic [31:0] wr2_data [0:63];
  int          wr2_n = 0;
  int          b2b = 0;
  logic        prev_mw = 1'b0;
  logic        prev_mw2 = 1'b0;

  always @(negedge Clk) begin
    if (MemWrite) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] <= MemAddress;
        wr_data[wr_n] <= MemWriteData;
        wr_cyc[wr_n]  <= cyc - start_cyc + 1;
      end
      wr_n <= wr_n + 1;
    end
    if (MemWrite2) begin
      if (wr2_n < 64) begin
        wr2_addr[wr2_n] <= MemAddress2;
        wr2_data[wr2_n] <= MemWriteData2;
      end
      wr2_n <= wr2_n + 1;
    end
    if ((MemWrite && prev_mw) || (MemWrite2 && prev_mw2)) b2b <= b2b + 1;
    prev_mw  <= MemWrite;
    prev_mw2 <= MemWrite2;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [7:0] stream [0:31];
  int base, base2;

  // Start a load and stream nbytes from 'stream'; optional gap on odd cycles.
  task automatic do_load(input logic [8:0] wc, input int nbytes, input bit gaps,
                         output int done_rel);
    int   ptr;
    logic acc;
    base  = wr_n;
    base2 = wr2_n;
    Start = 1'b1;
    WordCount = wc;
    InValid = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    start_cyc = cyc;
    ptr = 0;
    done_rel = -1;
    for (int k = 0; k < 200; k++) begin
      if (Done) begin
        done_rel = cyc - start_cyc + 1;
        break;
      end
      InValid = (ptr < nbytes) && (!gaps || (k[0] == 1'b0));
      InByte  = (ptr < 32) ? stream[ptr] : 8'h00;
      acc = InValid && InReady;
      @(posedge Clk); #1;
      if (acc) ptr++;
    end
    InValid = 1'b0;
  endtask

  // Present one byte as soon as the loader is ready.
  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (InReady) begin
        InValid = 1'b1;
        InByte  = b;
        sent    = 1'b1;
      end
      @(posedge Clk); #1;
      InValid = 1'b0;
    end
    check("send_byte_ready", 32'(sent), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50; i++) begin
      if (Done) break;
      @(posedge Clk); #1;
    end
    check("wait_done", 32'(Done), 32'd1);
  endtask

  int dr;

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    WordCount = 9'd0;
    InByte = 8'h00;
    InValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    // Asynchronous reset values.
    check("rst_flags", 32'({CpuReset, InReady, MemWrite, Busy, Done}), 32'b10000);
    check("rst_addr", MemAddress, 32'd0);
    check("rst_wdata", MemWriteData, 32'd0);
    check("rst_csum", Checksum, 32'd0);
    check("rst_cpureset2", 32'(CpuReset2), 32'd1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Two-word load, InValid held high.
    stream[0] = 8'h8C; stream[1] = 8'h11; stream[2] = 8'h00; stream[3] = 8'h04;
    stream[4] = 8'h01; stream[5] = 8'h23; stream[6] = 8'h45; stream[7] = 8'h67;
    do_load(9'd2, 8, 1'b0, dr);
    check("two_nwr", 32'(wr_n - base), 32'd2);
    check("two_addr0", wr_addr[base], 32'h0);
    check("two_data0", wr_data[base], 32'h8C110004);
    check("two_cyc0", 32'(wr_cyc[base]), 32'd5);
    check("two_addr1", wr_addr[base+1], 32'h4);
    check("two_data1", wr_data[base+1], 32'h01234567);
    check("two_cyc1", 32'(wr_cyc[base+1]), 32'd10);
    check("two_done_cyc", 32'(dr), 32'd11);
    check("two_flags", 32'({CpuReset, Busy, Done}), 32'b001);
    check("two_csum", Checksum, 32'h8D324563);

    // Same stream with backpressure.
    do_load(9'd2, 8, 1'b1, dr);
    check("bp_nwr", 32'(wr_n - base), 32'd2);
    check("bp_addr0", wr_addr[base], 32'h0);
    check("bp_data0", wr_data[base], 32'h8C110004);
    check("bp_addr1", wr_addr[base+1], 32'h4);
    check("bp_data1", wr_data[base+1], 32'h01234567);
    check("bp_csum", Checksum, 32'h8D324563);

    // Restart from DONE, then a Start pulse during RECV is ignored.
    base = wr_n;
    Start = 1'b1;
    WordCount = 9'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("restart_cpureset", 32'(CpuReset), 32'd1);
    check("restart_csum", Checksum, 32'd0);
    check("restart_busy", 32'(Busy), 32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    Start = 1'b1;
    WordCount = 9'd0;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("ign_start_busy", 32'({Busy, InReady, Done}), 32'b110);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_done();
    check("ign_nwr", 32'(wr_n - base), 32'd1);
    check("ign_addr", wr_addr[base], 32'h0);
    check("ign_data", wr_data[base], 32'hAABBCCDD);
    check("ign_csum", Checksum, 32'hAABBCCDD);

    // Reset after six bytes of a two-word load.
    Start = 1'b1;
    WordCount = 9'd2;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i));
    #2 Reset = 1'b0;
    #1;
    check("midrst_flags", 32'({CpuReset, InReady, MemWrite, Busy, Done}), 32'b10000);
    check("midrst_addr", MemAddress, 32'd0);
    check("midrst_wdata", MemWriteData, 32'd0);
    check("midrst_csum", Checksum, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE; stream[3] = 8'hEF;
    do_load(9'd1, 4, 1'b0, dr);
    check("post_rst_nwr", 32'(wr_n - base), 32'd1);
    check("post_rst_addr", wr_addr[base], 32'h0);
    check("post_rst_data", wr_data[base], 32'hDEADBEEF);
    check("post_rst_done_cyc", 32'(dr), 32'd6);

    // Zero count.
    do_load(9'd0, 0, 1'b0, dr);
    check("zero_done_cyc", 32'(dr), 32'd1);
    check("zero_nwr", 32'(wr_n - base), 32'd0);
    check("zero_flags", 32'({CpuReset, Done}), 32'b01);
    check("zero_csum", Checksum, 32'd0);

    // Capacity clamp on the 2-bit instance: 7 requested, 4 written.
    for (int j = 0; j < 32; j++) stream[j] = 8'(8'h30 + j);
    do_load(9'd7, 28, 1'b0, dr);
    check("cap_nwr1", 32'(wr_n - base), 32'd7);
    check("cap_last_addr1", wr_addr[base+6], 32'h18);
    check("cap_nwr2", 32'(wr2_n - base2), 32'd4);
    check("cap_addr0", wr2_addr[base2], 32'h0);
    check("cap_addr1", wr2_addr[base2+1], 32'h4);
    check("cap_addr2", wr2_addr[base2+2], 32'h8);
    check("cap_addr3", wr2_addr[base2+3], 32'hC);
    check("cap_data3", wr2_data[base2+3], 32'h3C3D3E3F);
    check("cap_done2", 32'({CpuReset2, Done2}), 32'b01);

    check("memwrite_b2b", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time writer for the instruction memory read by the instruction fetch unit. It accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. Each word goes to the instruction memory write port at consecutive byte addresses (0, 4, 8, …), matching the fetch unit's PC addressing. While loading, it holds the fetch unit in reset through `CpuReset`, and releases it once the requested word count has been written.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: word-index width; capacity is 2^ADDR_WIDTH words.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  begin a load; sampled in IDLE and DONE only.
- `WordCount`  in  ADDR_WIDTH+1  number of words to load; latched when `Start` is accepted.
- `InByte`  in  8  stream data byte.
- `InValid`  in  1  `InByte` is valid.
- `InReady`  out  1  loader accepts a byte this cycle.
- `MemWrite`  out  1  one-cycle instruction-memory write strobe.
- `MemAddress`  out  32  byte address, equal to word index × 4.
- `MemWriteData`  out  32  assembled word.
- `CpuReset`  out  1  active-high reset to the fetch unit.
- `Busy`  out  1  high in RECV and WRITE.
- `Done`  out  1  high in DONE.
- `Checksum`  out  32  XOR of all words written in the current load.

## Operation
- **States:** IDLE, RECV, WRITE, DONE.
- **Reset values** (`Reset`=0, asynchronous):
  - state IDLE.
  - `CpuReset`=1.
  - `InReady`=0, `MemWrite`=0, `Busy`=0, `Done`=0.
  - `MemAddress`=0, `MemWriteData`=0, `Checksum`=0.
  - internal byte index, word index and latched count all 0.
- **IDLE:**
  - On `Start`=1, latch the count, clear `Checksum`, clear both indices, and keep `CpuReset`=1.
  - The latched count is `WordCount`, clamped to 2^ADDR_WIDTH if larger.
  - Count 0 → DONE; otherwise → RECV.
- **RECV:**
  - `InReady`=1.
  - A byte transfers when `InValid` and `InReady` are both high at a rising edge.
  - Byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - After the 4th byte transfers → WRITE.
  - Cycles with `InValid`=0 hold all state.
- **WRITE:** exactly one cycle.
  - `MemWrite`=1, `InReady`=0.
  - `MemAddress` = {word index, 2'b00}, zero-extended to 32 bits.
  - `MemWriteData` = assembled word.
  - `Checksum` ← `Checksum` ^ word at the exiting edge.
  - Word index increments and byte index clears.
  - If the incremented index equals the count → DONE; else → RECV.
- **DONE:**
  - `CpuReset`=0, `Done`=1, `InReady`=0.
  - `Checksum` and `MemAddress` hold.
  - `Start`=1 restarts exactly as from IDLE and drives `CpuReset`=1 again on the next cycle.
- **Edge cases:**
  - `Start` in RECV or WRITE is ignored.
  - `WordCount` changes after latch have no effect.
  - A full-capacity load (count = 2^ADDR_WIDTH) ends at word index 2^ADDR_WIDTH−1 with no address wrap.
  - A reset mid-load returns every output to its reset value immediately. Memory already written is not erased.

## Timing
- `Start` accepted at edge t → state RECV and `InReady`=1 from t+1. For count 0, `Done`=1 and `CpuReset`=0 from t+1.
- With `InValid` held high, each word takes 4 RECV cycles plus 1 WRITE cycle.
- An N-word load asserts `Done` 5N+1 cycles after the `Start` edge.
- `MemWrite` is never high on two consecutive cycles.
- `MemAddress` and `MemWriteData` are valid whenever `MemWrite`=1.
- `CpuReset` falls in the same cycle `Done` rises.

## Test plan
- **Reset:** assert `Reset`=0 mid-cycle → all outputs at their reset values asynchronously, `CpuReset`=1.
- **Two-word load:** `WordCount`=2, stream 8C 11 00 04 then 01 23 45 67 with `InValid` held high → two writes:
  - 0x8C110004 @0 and 0x01234567 @4, at cycles 5 and 10 after `Start`.
  - `Done`=1 and `CpuReset`=0 at cycle 11.
  - `Checksum`=0x8D324563.
- **Backpressure:** same stream with `InValid` low on alternate cycles → identical write data and addresses; no byte lost or duplicated.
- **Zero count:** `WordCount`=0 → `Done`=1 one cycle after `Start`; no `MemWrite`.
- **Ignored start / reset mid-load:**
  - `Start` pulsed during RECV → no effect on state or indices.
  - `Reset` low after 6 bytes → IDLE, `InReady`=0, `CpuReset`=1; a new 1-word load then writes its word at address 0.
- **Reload and capacity:**
  - `Start` from DONE → `CpuReset`=1 next cycle and `Checksum` cleared.
  - `ADDR_WIDTH`=2 with `WordCount`=7 → clamped to 4 writes, at addresses 0, 4, 8, C.
